// File: rtl/rob_multi_wb_pkg.sv
// rob_multi_wb_pkg: shared widths and constants for the multi-writeback reorder buffer
package rob_multi_wb_pkg;
    localparam int ROB_DEPTH = 32;
    localparam int ROB_TAG_W = 5;
    localparam int ROB_DATA_W = 32;
    localparam int ROB_ADDR_W = 32;
    localparam int ROB_REG_W = 5;
    localparam int ROB_NUM_WB = 2;
    localparam logic [ROB_TAG_W-1:0] TAG_NONE = '0;
    localparam logic STORE = 1'b1;
    localparam logic NOT_JUMP = 1'b0;
endpackage

// File: rtl/rob_ptr_inc.sv
// rob_ptr_inc: wrapping pointer increment that skips the reserved tag 0
module rob_ptr_inc #(
    parameter int TAG_W = 5
) (
    input  logic [TAG_W-1:0] cur,
    output logic [TAG_W-1:0] nxt
);
    assign nxt = (cur == {TAG_W{1'b1}}) ? TAG_W'(1) : cur + TAG_W'(1);
endmodule

// File: rtl/rob_multi_wb.sv
// rob_multi_wb: in-order-commit reorder buffer with several writeback ports,
// store retire handshake and flush on a mispredicted branch at the head
module rob_multi_wb
    import rob_multi_wb_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int TAG_W  = ROB_TAG_W,
    parameter int DATA_W = ROB_DATA_W,
    parameter int ADDR_W = ROB_ADDR_W,
    parameter int REG_W  = ROB_REG_W,
    parameter int NUM_WB = ROB_NUM_WB
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     alloc_en,
    input  logic [REG_W-1:0]         alloc_regnm,
    input  logic                     alloc_store,
    input  logic                     alloc_pd,
    output logic                     alloc_ok,
    output logic [TAG_W-1:0]         alloc_tag,
    output logic                     full,
    input  logic [NUM_WB-1:0]        wb_en,
    input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
    input  logic [NUM_WB*DATA_W-1:0] wb_dt,
    input  logic [NUM_WB-1:0]        wb_ac,
    input  logic [NUM_WB*ADDR_W-1:0] wb_jpc,
    output logic                     st_req,
    output logic [TAG_W-1:0]         st_tag,
    input  logic                     st_ack,
    output logic                     cm_en,
    output logic [REG_W-1:0]         cm_regnm,
    output logic [DATA_W-1:0]        cm_dt,
    output logic [TAG_W-1:0]         cm_tag,
    output logic                     flush,
    output logic [ADDR_W-1:0]        flush_pc
);
    logic [DEPTH-1:0]  valid, done, store, pd, ac;
    logic [REG_W-1:0]  regnm [DEPTH];
    logic [DATA_W-1:0] dt [DEPTH];
    logic [ADDR_W-1:0] jpc [DEPTH];
    logic [TAG_W-1:0]  head, tail, head_nx, tail_nx, count;
    logic [TAG_W-1:0]  wt [NUM_WB];
    logic [DATA_W-1:0] wd [NUM_WB];
    logic [ADDR_W-1:0] wj [NUM_WB];
    logic retire_alu, retire_st, mispred;

    for (genvar i = 0; i < NUM_WB; i++) begin : g_wb
        assign wt[i] = wb_tag[i*TAG_W +: TAG_W];
        assign wd[i] = wb_dt[i*DATA_W +: DATA_W];
        assign wj[i] = wb_jpc[i*ADDR_W +: ADDR_W];
    end

    rob_ptr_inc #(.TAG_W(TAG_W)) u_head_inc (.cur(head), .nxt(head_nx));
    rob_ptr_inc #(.TAG_W(TAG_W)) u_tail_inc (.cur(tail), .nxt(tail_nx));

    assign full       = count == TAG_W'(DEPTH - 1);
    assign alloc_ok   = alloc_en && !full && !flush && rdy;
    assign alloc_tag  = tail;
    assign st_req     = valid[head] && store[head] == STORE && done[head];
    assign st_tag     = st_req ? head : TAG_W'(TAG_NONE);
    assign retire_alu = rdy && valid[head] && store[head] != STORE && done[head];
    assign retire_st  = rdy && st_req && st_ack;
    assign mispred    = retire_alu && pd[head] != ac[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= '0;
            pd       <= {DEPTH{NOT_JUMP}};
            head     <= TAG_W'(1);
            tail     <= TAG_W'(1);
            count    <= '0;
            cm_en    <= 1'b0;
            flush    <= 1'b0;
            cm_regnm <= '0;
            cm_dt    <= '0;
            cm_tag   <= '0;
            flush_pc <= '0;
        end else if (rdy) begin
            cm_en <= retire_alu;
            flush <= mispred;
            if (retire_alu) begin
                cm_regnm <= regnm[head];
                cm_dt    <= dt[head];
                cm_tag   <= head;
            end
            if (mispred)
                flush_pc <= jpc[head];
            // highest index first so port 0 lands last and wins a tag collision
            for (int p = NUM_WB - 1; p >= 0; p--)
                if (wb_en[p] && valid[wt[p]]) begin
                    done[wt[p]] <= 1'b1;
                    ac[wt[p]]   <= wb_ac[p];
                    dt[wt[p]]   <= wd[p];
                    jpc[wt[p]]  <= wj[p];
                end
            if (alloc_ok) begin
                valid[tail] <= 1'b1;
                done[tail]  <= 1'b0;
                store[tail] <= alloc_store;
                pd[tail]    <= alloc_pd;
                regnm[tail] <= alloc_regnm;
                tail        <= tail_nx;
            end
            if (retire_alu || retire_st) begin
                valid[head] <= 1'b0;
                head        <= head_nx;
            end
            count <= count + TAG_W'(alloc_ok) - TAG_W'(retire_alu || retire_st);
            if (mispred) begin
                valid <= '0;
                head  <= TAG_W'(1);
                tail  <= TAG_W'(1);
                count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_rob_multi_wb.sv
// tb_rob_multi_wb: vector table, directed corner sequences and a queue-based random model
module tb_rob_multi_wb;
    localparam int TW = 5, DW = 32, AW = 32, RW = 5, NW = 2;

    logic clk = 1'b0, rst, rdy, alloc_en, alloc_store, alloc_pd, st_ack;
    logic alloc_ok, full, st_req, cm_en, flush;
    logic [RW-1:0] alloc_regnm, cm_regnm;
    logic [TW-1:0] alloc_tag, st_tag, cm_tag;
    logic [NW-1:0] wb_en, wb_ac;
    logic [NW*TW-1:0] wb_tag;
    logic [NW*DW-1:0] wb_dt;
    logic [NW*AW-1:0] wb_jpc;
    logic [DW-1:0] cm_dt;
    logic [AW-1:0] flush_pc;
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    rob_multi_wb dut (
        .clk(clk), .rst(rst), .rdy(rdy), .alloc_en(alloc_en), .alloc_regnm(alloc_regnm),
        .alloc_store(alloc_store), .alloc_pd(alloc_pd), .alloc_ok(alloc_ok), .alloc_tag(alloc_tag),
        .full(full), .wb_en(wb_en), .wb_tag(wb_tag), .wb_dt(wb_dt), .wb_ac(wb_ac), .wb_jpc(wb_jpc),
        .st_req(st_req), .st_tag(st_tag), .st_ack(st_ack), .cm_en(cm_en), .cm_regnm(cm_regnm),
        .cm_dt(cm_dt), .cm_tag(cm_tag), .flush(flush), .flush_pc(flush_pc)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic idle();
        rdy = 1; alloc_en = 0; alloc_store = 0; alloc_pd = 0; alloc_regnm = 0;
        wb_en = 0; wb_tag = 0; wb_dt = 0; wb_ac = 0; wb_jpc = 0; st_ack = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic alloc(input logic st, input logic p, input int r);
        alloc_en = 1; alloc_store = st; alloc_pd = p; alloc_regnm = RW'(r);
    endtask

    task automatic wb(input int port, input int t, input logic [31:0] d, input logic a, input logic [31:0] j);
        wb_en[port] = 1; wb_tag[port*TW +: TW] = TW'(t); wb_dt[port*DW +: DW] = d;
        wb_ac[port] = a; wb_jpc[port*AW +: AW] = j;
    endtask

    typedef struct {
        logic ae; int rg; logic [1:0] we; int t0, d0, t1, d1;
        logic ok; int tag; logic cm; int ctag, cdt;
    } vec_t;
    vec_t tv[16];

    typedef struct {
        logic [4:0] tag, rg; logic st, pd, done, ac; logic [31:0] dt, jpc;
    } ent_t;
    ent_t q[$];
    logic [4:0] m_next, m_ctag, m_crg;
    logic m_cm, m_fl;
    logic [31:0] m_cdt, m_fpc;

    initial begin
        // ae rg we t0 d0 t1 d1 | ok tag | cm ctag cdt
        tv[0]  = '{1, 1, 2'b00, 0, 0, 0, 0,        1, 1, 0, 0, 0};
        tv[1]  = '{1, 2, 2'b00, 0, 0, 0, 0,        1, 2, 0, 0, 0};
        tv[2]  = '{1, 3, 2'b00, 0, 0, 0, 0,        1, 3, 0, 0, 0};
        tv[3]  = '{0, 0, 2'b01, 3, 'h33, 0, 0,     0, 4, 0, 0, 0};
        tv[4]  = '{0, 0, 2'b10, 0, 0, 2, 'h22,     0, 4, 0, 0, 0};
        tv[5]  = '{0, 0, 2'b01, 1, 'h11, 0, 0,     0, 4, 0, 0, 0};
        tv[6]  = '{0, 0, 2'b00, 0, 0, 0, 0,        0, 4, 1, 1, 'h11};
        tv[7]  = '{1, 4, 2'b00, 0, 0, 0, 0,        1, 4, 1, 2, 'h22};
        tv[8]  = '{1, 5, 2'b00, 0, 0, 0, 0,        1, 5, 1, 3, 'h33};
        tv[9]  = '{0, 0, 2'b11, 5, 'hA, 5, 'hB,    0, 6, 0, 3, 'h33};
        tv[10] = '{0, 0, 2'b10, 0, 0, 4, 'h44,     0, 6, 0, 3, 'h33};
        tv[11] = '{0, 0, 2'b00, 0, 0, 0, 0,        0, 6, 1, 4, 'h44};
        tv[12] = '{0, 0, 2'b00, 0, 0, 0, 0,        0, 6, 1, 5, 'hA};
        tv[13] = '{0, 0, 2'b00, 0, 0, 0, 0,        0, 6, 0, 5, 'hA};
        tv[14] = '{0, 0, 2'b01, 5, 'h77, 0, 0,     0, 6, 0, 5, 'hA};
        tv[15] = '{1, 6, 2'b00, 0, 0, 0, 0,        1, 6, 0, 5, 'hA};

        do_reset();
        chk("rst cm_en", cm_en, 0);
        chk("rst flush", flush, 0);
        chk("rst st_req", st_req, 0);
        chk("rst alloc_tag", alloc_tag, 1);
        chk("rst cm_dt", cm_dt, 0);
        chk("rst flush_pc", flush_pc, 0);

        for (int i = 0; i < 16; i++) begin
            idle();
            if (tv[i].ae) alloc(0, 0, tv[i].rg);
            if (tv[i].we[0]) wb(0, tv[i].t0, tv[i].d0, 0, 0);
            if (tv[i].we[1]) wb(1, tv[i].t1, tv[i].d1, 0, 0);
            #1;
            chk($sformatf("vec%0d alloc_ok", i), alloc_ok, tv[i].ok);
            chk($sformatf("vec%0d alloc_tag", i), alloc_tag, tv[i].tag);
            step();
            chk($sformatf("vec%0d cm_en", i), cm_en, tv[i].cm);
            chk($sformatf("vec%0d cm_tag", i), cm_tag, tv[i].ctag);
            chk($sformatf("vec%0d cm_dt", i), cm_dt, tv[i].cdt);
        end

        // fill to capacity, then retire one and wrap the tail to tag 1
        do_reset();
        for (int i = 1; i <= 31; i++) begin
            idle(); alloc(0, 0, i); step();
        end
        idle(); alloc_en = 1; #1;
        chk("fill full", full, 1);
        chk("fill alloc_ok", alloc_ok, 0);
        chk("fill wrap tag", alloc_tag, 1);
        step();
        idle(); wb(0, 1, 'h5, 0, 0); step();
        idle(); step();
        chk("fill cm_en", cm_en, 1);
        chk("fill cm_tag", cm_tag, 1);
        chk("fill not full", full, 0);
        alloc(0, 0, 9); #1;
        chk("wrap alloc_ok", alloc_ok, 1);
        chk("wrap alloc_tag", alloc_tag, 1);
        step();
        chk("refill full", full, 1);
        chk("refill tail", alloc_tag, 2);

        // store handshake, including a stray ack and an ack held off by rdy=0
        do_reset();
        alloc(1, 0, 3); step();
        idle(); alloc(0, 0, 4); step();
        idle(); st_ack = 1; #1;
        chk("st not done", st_req, 0);
        step();
        idle(); wb(0, 1, 'hAB, 0, 0); step();
        for (int i = 0; i < 3; i++) begin
            idle(); #1;
            chk($sformatf("st_req c%0d", i), st_req, 1);
            chk($sformatf("st_tag c%0d", i), st_tag, 1);
            step();
            chk($sformatf("st cm_en c%0d", i), cm_en, 0);
        end
        idle(); rdy = 0; st_ack = 1; step();
        chk("st rdy0 hold", st_req, 1);
        idle(); st_ack = 1; step();
        chk("st ack cm_en", cm_en, 0);
        chk("st ack req", st_req, 0);
        idle(); wb(0, 2, 'hCD, 0, 0); step();
        idle(); step();
        chk("st next cm_tag", cm_tag, 2);
        chk("st next cm_dt", cm_dt, 'hCD);

        // mispredicted branch at tag 2
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            idle(); alloc(0, 0, i); step();
        end
        idle(); wb(0, 1, 'h1, 0, 'h2000); wb(1, 2, 'h2, 1, 'h1040); step();
        idle(); step();
        chk("br1 cm", cm_tag, 1);
        chk("br1 flush", flush, 0);
        step();
        chk("br2 cm_en", cm_en, 1);
        chk("br2 cm_tag", cm_tag, 2);
        chk("br2 flush", flush, 1);
        chk("br2 flush_pc", flush_pc, 'h1040);
        alloc(0, 0, 7); wb(0, 3, 'h3, 0, 0); #1;
        chk("br alloc_ok in flush", alloc_ok, 0);
        chk("br alloc_tag", alloc_tag, 1);
        chk("br not full", full, 0);
        step();
        chk("br flush pulse", flush, 0);
        chk("br no cm", cm_en, 0);
        idle(); alloc(0, 0, 7); #1;
        chk("br alloc after", alloc_ok, 1);
        step();
        idle(); wb(0, 1, 'h99, 0, 0); step();
        idle(); step();
        chk("br post cm_tag", cm_tag, 1);
        chk("br post cm_regnm", cm_regnm, 7);

        // reset in the middle of a store handshake
        do_reset();
        alloc(1, 0, 1); step();
        idle(); alloc(0, 0, 2); wb(0, 1, 'h1, 0, 0); step();
        for (int i = 0; i < 8; i++) begin
            idle(); alloc(0, 0, i); step();
        end
        idle(); #1;
        chk("mid st_req", st_req, 1);
        rst = 1; step(); rst = 0;
        chk("mid rst st_req", st_req, 0);
        chk("mid rst cm_en", cm_en, 0);
        chk("mid rst tag", alloc_tag, 1);
        for (int i = 0; i < 30; i++) begin
            idle(); alloc(0, 0, i); step();
        end
        chk("mid count 30", full, 0);
        idle(); alloc(0, 0, 1); step();
        chk("mid count 31", full, 1);

        // random traffic against a queue model
        do_reset();
        q.delete(); m_next = 1; m_cm = 0; m_fl = 0; m_ctag = 0; m_crg = 0; m_cdt = 0; m_fpc = 0;
        for (int c = 0; c < 3000; c++) begin
            logic e_ok, e_st, ret_alu, mis;
            idle();
            rdy = $urandom_range(9) != 0;
            alloc_en = $urandom_range(2) != 0;
            alloc_store = $urandom_range(3) == 0;
            alloc_pd = 1'($urandom);
            alloc_regnm = RW'($urandom);
            st_ack = $urandom_range(2) == 0;
            for (int p = 0; p < NW; p++) begin
                logic [4:0] t;
                logic a;
                t = 5'($urandom_range(31));
                a = 1'($urandom);
                if (q.size() > 0 && $urandom_range(7) != 0) begin
                    int k;
                    k = $urandom_range(q.size() - 1);
                    t = q[k].tag;
                    a = ($urandom_range(15) == 0) ? ~q[k].pd : q[k].pd;
                end
                wb_en[p] = $urandom_range(9) < 6;
                wb_tag[p*TW +: TW] = t;
                wb_ac[p] = a;
                wb_dt[p*DW +: DW] = $urandom;
                wb_jpc[p*AW +: AW] = $urandom;
            end
            #1;
            e_ok = alloc_en && rdy && q.size() < 31 && !m_fl;
            e_st = q.size() > 0 && q[0].st && q[0].done;
            chk("rnd alloc_ok", alloc_ok, e_ok);
            chk("rnd alloc_tag", alloc_tag, m_next);
            chk("rnd full", full, q.size() == 31);
            chk("rnd st_req", st_req, e_st);
            if (e_st) chk("rnd st_tag", st_tag, q[0].tag);
            if (rdy) begin
                ret_alu = q.size() > 0 && !q[0].st && q[0].done;
                mis = ret_alu && q[0].pd != q[0].ac;
                m_cm = ret_alu;
                m_fl = mis;
                if (ret_alu) begin
                    m_ctag = q[0].tag; m_crg = q[0].rg; m_cdt = q[0].dt;
                end
                if (mis) m_fpc = q[0].jpc;
                for (int p = NW - 1; p >= 0; p--)
                    if (wb_en[p])
                        foreach (q[k])
                            if (q[k].tag == wb_tag[p*TW +: TW]) begin
                                q[k].done = 1; q[k].ac = wb_ac[p];
                                q[k].dt = wb_dt[p*DW +: DW]; q[k].jpc = wb_jpc[p*AW +: AW];
                            end
                if (ret_alu || (e_st && st_ack)) void'(q.pop_front());
                if (mis) begin
                    q.delete();
                    m_next = 1;
                end else if (e_ok) begin
                    q.push_back('{m_next, alloc_regnm, alloc_store, alloc_pd, 1'b0, 1'b0, 32'h0, 32'h0});
                    m_next = (m_next == 31) ? 5'd1 : m_next + 5'd1;
                end
            end
            step();
            chk("rnd cm_en", cm_en, m_cm);
            chk("rnd cm_tag", cm_tag, m_ctag);
            chk("rnd cm_regnm", cm_regnm, m_crg);
            chk("rnd cm_dt", cm_dt, m_cdt);
            chk("rnd flush", flush, m_fl);
            chk("rnd flush_pc", flush_pc, m_fpc);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
